// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its write/read scheduler.
package instr_register_pkg;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic        [4:0]  address_t;
    typedef logic signed [63:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  result;
    } instruction_t;

    localparam int NUM_REQ = 2;

    // A divide or modulo by zero is never stored; the scheduler consumes and flags it.
    function automatic logic is_div0(input opcode_t opc, input operand_t op_b);
        return ((opc == DIV) || (opc == MOD)) && (op_b == '0);
    endfunction

endpackage

// File: rtl/instr_register.sv
// 32-entry instruction register: computes the result at load time, reads combinationally.
module instr_register
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         load_en,
    input  opcode_t      opcode,
    input  operand_t     operand_a,
    input  operand_t     operand_b,
    input  address_t     write_pointer,
    input  address_t     read_pointer,
    output instruction_t instruction_word
);

    instruction_t mem_q [DEPTH];
    result_t      a_ext;
    result_t      b_ext;
    result_t      result;

    // Result of the incoming instruction, evaluated in 64 bits so MULT cannot overflow.
    always_comb begin
        a_ext  = result_t'(operand_a);
        b_ext  = result_t'(operand_b);
        result = '0;
        unique case (opcode)
            ZERO:    result = '0;
            PASSA:   result = a_ext;
            PASSB:   result = b_ext;
            ADD:     result = a_ext + b_ext;
            SUB:     result = a_ext - b_ext;
            MULT:    result = a_ext * b_ext;
            DIV:     result = (b_ext == '0) ? '0 : a_ext / b_ext;
            MOD:     result = (b_ext == '0) ? '0 : a_ext % b_ext;
            default: result = '0;
        endcase
    end

    // Storage write.
    // NOTE: the array has no reset; entries are only read after being written, and a reset would turn it into flops.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b, result: result};
        end
    end

    assign instruction_word = mem_q[read_pointer];

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the requester granted last loses a tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic rr_last_q;
    logic rr_last_d;

    // Grant selection and pointer update; a tie goes to the requester that did not win last.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        grant     = 2'b00;
        rr_last_d = rr_last_q;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (clear) begin
            rr_last_d = 1'b1;
        end else if (advance) begin
            rr_last_d = grant[1];
        end
    end

    // Last-grant register; resets to 1 so requester 0 wins the first tie.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/instr_reg_sched.sv
// Write-side arbiter and read-side sequencer treating the instruction register as a circular queue.
module instr_reg_sched
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 32,              // must equal 2**$bits(address_t) so pointers wrap naturally
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic    [NUM_REQ-1:0] req_valid,
    output logic    [NUM_REQ-1:0] req_ready,
    input  opcode_t [NUM_REQ-1:0] req_opcode,
    input  operand_t [NUM_REQ-1:0] req_operand_a,
    input  operand_t [NUM_REQ-1:0] req_operand_b,
    output logic                  load_en,
    output opcode_t               opcode,
    output operand_t              operand_a,
    output operand_t              operand_b,
    output address_t              write_pointer,
    output address_t              read_pointer,
    input  instruction_t          instruction_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output instruction_t          out_word,
    output logic                  err_div0,
    output logic    [CNT_W-1:0]   count
);

    address_t           wr_ptr_q, wr_ptr_d;
    address_t           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_div0_q, err_div0_d;

    logic [NUM_REQ-1:0] div0_req;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               full;
    logic               accept_en;
    logic               sel;
    logic               granted_div0;
    logic               push;
    logic               pop;

    // Nothing is accepted while reset is held or during a flush cycle.
    assign accept_en = reset_n && !flush;
    assign full      = (count_q == CNT_W'(DEPTH));

    // Eligibility: a full queue blocks normal requests, but a div0 request is always consumable.
    always_comb begin
        div0_req = '0;
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            div0_req[i] = is_div0(req_opcode[i], req_operand_b[i]);
            eligible[i] = accept_en && req_valid[i] && (!full || div0_req[i]);
        end
    end

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .req     (eligible),
        .advance (|eligible),
        .grant   (grant)
    );

    assign req_ready    = grant;
    assign sel          = grant[1];
    assign granted_div0 = |(grant & div0_req);
    assign push         = (|grant) && !granted_div0;
    assign out_valid    = (count_q != '0);
    assign pop          = out_valid && out_ready && !flush;

    // Register write port driven straight from the granted requester in the grant cycle.
    always_comb begin
        load_en   = push;
        opcode    = ZERO;
        operand_a = '0;
        operand_b = '0;
        if (push) begin
            opcode    = req_opcode[sel];
            operand_a = req_operand_a[sel];
            operand_b = req_operand_b[sel];
        end
    end

    // Queue bookkeeping; flush overrides any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_div0_d = granted_div0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + address_t'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + address_t'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_div0_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_div0_q <= err_div0_d;
        end
    end

    assign write_pointer = wr_ptr_q;
    assign read_pointer  = rd_ptr_q;
    assign out_word      = instruction_word;
    assign err_div0      = err_div0_q;
    assign count         = count_q;

endmodule

// File: tb/tb_instr_reg_sched.sv
// Scoreboard bench for instr_reg_sched connected to instr_register.
module tb_instr_reg_sched;
    import instr_register_pkg::*;

    localparam int DEPTH = 32;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   flush;
    logic     [1:0]         req_valid;
    logic     [1:0]         req_ready;
    opcode_t  [1:0]         req_opcode;
    operand_t [1:0]         req_operand_a;
    operand_t [1:0]         req_operand_b;
    logic                   load_en;
    opcode_t                opcode;
    operand_t               operand_a;
    operand_t               operand_b;
    address_t               write_pointer;
    address_t               read_pointer;
    instruction_t           instruction_word;
    logic                   out_valid;
    logic                   out_ready;
    instruction_t           out_word;
    logic                   err_div0;
    logic     [CNT_W-1:0]   count;

    int n_cmp = 0;
    int n_bad = 0;
    instruction_t sb [$];

    always #5 clk = ~clk;

    instr_reg_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .flush            (flush),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_opcode       (req_opcode),
        .req_operand_a    (req_operand_a),
        .req_operand_b    (req_operand_b),
        .load_en          (load_en),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_word         (out_word),
        .err_div0         (err_div0),
        .count            (count)
    );

    instr_register #(.DEPTH(DEPTH)) u_reg (
        .clk              (clk),
        .load_en          (load_en),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input instruction_t act, input instruction_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got opc=%0d a=%0d b=%0d r=%0d expected opc=%0d a=%0d b=%0d r=%0d",
                     name, act.opc, act.op_a, act.op_b, act.result,
                     exp.opc, exp.op_a, exp.op_b, exp.result);
        end
    endtask

    function automatic instruction_t mk(input opcode_t o, input int a, input int b, input longint r);
        instruction_t w;
        w.opc    = o;
        w.op_a   = operand_t'(a);
        w.op_b   = operand_t'(b);
        w.result = result_t'(r);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
    endtask

    task automatic set_req(input int idx, input opcode_t o, input int a, input int b);
        req_opcode[idx]    = o;
        req_operand_a[idx] = operand_t'(a);
        req_operand_b[idx] = operand_t'(b);
    endtask

    // Monitor: every accepted output word is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got result %0d with nothing expected", out_word.result);
            end else begin
                check_word("sb_out_word", out_word, sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        int accepted;
        reset_n   = 1'b0;
        flush     = 1'b0;
        req_valid = 2'b00;
        out_ready = 1'b0;
        set_req(0, ZERO, 0, 0);
        set_req(1, ZERO, 0, 0);
        repeat (3) tick();

        // Reset state
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_load_en", 64'(load_en), 64'd0);
        check("rst_opcode", 64'(opcode), 64'(ZERO));
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_err_div0", 64'(err_div0), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_wp", 64'(write_pointer), 64'd0);
        check("rst_rp", 64'(read_pointer), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single ADD from requester 0
        set_req(0, ADD, 5, 3);
        req_valid = 2'b01;
        #1;
        check("t1_ready", 64'(req_ready), 64'b01);
        check("t1_load_en", 64'(load_en), 64'd1);
        check("t1_opcode", 64'(opcode), 64'(ADD));
        check("t1_wp", 64'(write_pointer), 64'd0);
        sb.push_back(mk(ADD, 5, 3, 8));
        tick();
        req_valid = 2'b00;
        #1;
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_count", 64'(count), 64'd1);
        drain(1);
        check("t1_count_after", 64'(count), 64'd0);

        // Round-robin alternation after a flush restores requester 0 priority
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_req(0, PASSA, 1, 0);
        set_req(1, PASSA, 2, 0);
        for (int k = 0; k < 4; k++) begin
            req_valid = 2'b11;
            #1;
            check("t2_grant", 64'(req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
            check("t2_wp", 64'(write_pointer), 64'(k));
            sb.push_back(mk(PASSA, (k % 2 == 0) ? 1 : 2, 0, (k % 2 == 0) ? 1 : 2));
            tick();
        end
        req_valid = 2'b00;
        #1;
        check("t2_count", 64'(count), 64'd4);
        drain(4);
        check("t2_count_after", 64'(count), 64'd0);
        check("t2_rp", 64'(read_pointer), 64'd4);

        // Fill to 32, div0 while full, pop then wrap to entry 0
        flush = 1'b1;
        tick();
        flush = 1'b0;
        accepted = 0;
        for (int k = 0; k < 32; k++) begin
            set_req(0, PASSA, 100 + k, 0);
            req_valid = 2'b01;
            #1;
            if (req_ready == 2'b01) accepted++;
            sb.push_back(mk(PASSA, 100 + k, 0, 100 + k));
            tick();
        end
        check("t3_accepted", 64'(accepted), 64'd32);
        check("t3_count_full", 64'(count), 64'd32);
        set_req(0, PASSA, 200, 0);
        #1;
        check("t3_full_ready", 64'(req_ready), 64'd0);
        check("t3_full_load", 64'(load_en), 64'd0);
        set_req(1, DIV, 9, 0);
        req_valid = 2'b11;
        #1;
        check("t3_div0_full_ready", 64'(req_ready), 64'b10);
        tick();
        req_valid = 2'b01;
        #1;
        check("t3_div0_err", 64'(err_div0), 64'd1);
        check("t3_count_kept", 64'(count), 64'd32);
        out_ready = 1'b1;
        #1;
        check("t3_full_pop_ready", 64'(req_ready), 64'd0);
        tick();
        out_ready = 1'b0;
        #1;
        check("t3_count_31", 64'(count), 64'd31);
        check("t3_resume_ready", 64'(req_ready), 64'b01);
        check("t3_wrap_wp", 64'(write_pointer), 64'd0);
        sb.push_back(mk(PASSA, 200, 0, 200));
        tick();
        req_valid = 2'b00;
        #1;
        check("t3_count_refull", 64'(count), 64'd32);
        drain(32);
        check("t3_count_empty", 64'(count), 64'd0);
        check("t3_out_valid_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t3_empty_rp_hold", 64'(read_pointer), 64'd1);
        check("t3_empty_count_hold", 64'(count), 64'd0);

        // DIV by zero rejected, MOD stored
        set_req(1, DIV, 7, 0);
        req_valid = 2'b10;
        #1;
        check("t4_div_ready", 64'(req_ready), 64'b10);
        check("t4_div_load", 64'(load_en), 64'd0);
        tick();
        set_req(1, MOD, 7, 2);
        #1;
        check("t4_err_pulse", 64'(err_div0), 64'd1);
        check("t4_mod_ready", 64'(req_ready), 64'b10);
        check("t4_mod_load", 64'(load_en), 64'd1);
        check("t4_mod_wp", 64'(write_pointer), 64'd1);
        sb.push_back(mk(MOD, 7, 2, 1));
        tick();
        req_valid = 2'b00;
        #1;
        check("t4_err_cleared", 64'(err_div0), 64'd0);
        check("t4_count", 64'(count), 64'd1);
        drain(1);

        // Flush while pushing
        for (int k = 0; k < 3; k++) begin
            set_req(0, PASSA, 40 + k, 0);
            req_valid = 2'b01;
            tick();
        end
        check("t5_count3", 64'(count), 64'd3);
        set_req(0, PASSA, 43, 0);
        flush = 1'b1;
        #1;
        check("t5_flush_ready", 64'(req_ready), 64'd0);
        check("t5_flush_load", 64'(load_en), 64'd0);
        tick();
        flush = 1'b0;
        req_valid = 2'b00;
        #1;
        check("t5_count0", 64'(count), 64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        set_req(0, PASSA, 55, 0);
        req_valid = 2'b01;
        #1;
        check("t5_wp0", 64'(write_pointer), 64'd0);
        check("t5_ready", 64'(req_ready), 64'b01);
        sb.push_back(mk(PASSA, 55, 0, 55));
        tick();
        req_valid = 2'b00;
        drain(1);

        // Asynchronous reset mid-burst
        for (int k = 0; k < 10; k++) begin
            set_req(0, PASSA, 60 + k, 0);
            req_valid = 2'b01;
            tick();
        end
        check("t6_count10", 64'(count), 64'd10);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_ready", 64'(req_ready), 64'd0);
        check("t6_rst_load", 64'(load_en), 64'd0);
        check("t6_rst_opcode", 64'(opcode), 64'(ZERO));
        check("t6_rst_count", 64'(count), 64'd0);
        check("t6_rst_out_valid", 64'(out_valid), 64'd0);
        check("t6_rst_wp", 64'(write_pointer), 64'd0);
        check("t6_rst_rp", 64'(read_pointer), 64'd0);
        tick();
        reset_n = 1'b1;
        set_req(0, PASSA, 77, 0);
        #1;
        check("t6_fresh_wp", 64'(write_pointer), 64'd0);
        check("t6_fresh_ready", 64'(req_ready), 64'b01);
        sb.push_back(mk(PASSA, 77, 0, 77));
        tick();
        req_valid = 2'b00;
        drain(1);

        @(negedge clk);
        check("sb_leftover", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_reg_sched.md
# instr_reg_sched

Write-side arbiter and read-side sequencer for the 32-entry instruction register. Two requesters submit instructions over valid/ready channels. The block grants one per cycle using round-robin and drives the register's load_en/opcode/operands/write_pointer. It also manages the register as a circular queue, exposing stored instruction words in write order to a single consumer over a valid/ready channel.

## Interface
Parameters:
- DEPTH, 32, number of register entries; must equal 2**$bits(address_t)
- CNT_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of queue state
- req_valid  in  [1:0]  requester i has an instruction
- req_ready  out  [1:0]  requester i's instruction accepted this cycle
- req_opcode  in  opcode_t [1:0]  per-requester opcode
- req_operand_a  in  operand_t [1:0]  per-requester operand A
- req_operand_b  in  operand_t [1:0]  per-requester operand B
- load_en  out  1  to register write enable
- opcode  out  opcode_t  to register
- operand_a, operand_b  out  operand_t  to register
- write_pointer  out  address_t  to register
- read_pointer  out  address_t  to register
- instruction_word  in  instruction_t  from register (combinational read)
- out_valid  out  1  head entry available
- out_ready  in  1  consumer takes head entry
- out_word  out  instruction_t  head entry (pass-through of instruction_word)
- err_div0  out  1  one-cycle pulse: DIV/MOD with operand_b==0 rejected
- count  out  CNT_W  occupied entries

## Operation
- State: wr_ptr, rd_ptr (address_t), count (0..DEPTH), rr_last (index of the last granted requester).
- Eligibility: requester i is eligible when req_valid[i] and count<DEPTH, or when its instruction is a div0 case (see below).
- Arbitration: if both are eligible, grant the one not equal to rr_last. rr_last updates only on grant. At most one grant per cycle. req_ready is combinational and one-hot or zero.
- Div0 rule: a granted request with opcode DIV or MOD and operand_b==0 is consumed (req_ready=1) but not written. It gives load_en=0 and err_div0=1 on the next cycle. Pointers and count are unchanged. This case is granted even when count==DEPTH.
- Normal write: load_en=1 with the granted opcode/operands and write_pointer=wr_ptr, all combinational in the grant cycle. wr_ptr increments mod DEPTH at the edge.
- Read: read_pointer=rd_ptr; out_valid = count!=0; out_word=instruction_word. A pop (out_valid&&out_ready) increments rd_ptr mod DEPTH.
- Count update: push only gives +1, pop only gives −1, push and pop together leave it unchanged. Push is allowed when full only if a pop occurs the same cycle? No: full blocks push regardless of pop.
- flush: takes priority over push/pop. wr_ptr, rd_ptr and count go to 0, and rr_last goes to 1. req_ready=0 and load_en=0 in the flush cycle. Register contents are not cleared.
- Reset mid-operation: all state is cleared immediately; queued entries are lost.

## Timing
- Reset values: req_ready=0, load_en=0, opcode=ZERO, operands=0, write_pointer=0, read_pointer=0, out_valid=0, err_div0=0, count=0, rr_last=1 (requester 0 wins first).
- A push at edge N makes the entry readable at cycle N+1: out_valid rises the cycle after the first push into an empty queue. There is no bypass.
- Sustained throughput: one push and one pop per cycle.
- Full (count==DEPTH): req_ready=0 for non-div0 requests. Once a pop occurs, push resumes on the following cycle.
- Empty: out_valid=0; out_ready is ignored.
- Wrap-around: both pointers roll from 31 to 0 with no gap.

## Structure
- instr_register_pkg supplies opcode_t, operand_t, address_t and instruction_t.
- Add to instr_register_pkg:
  - NUM_REQ=2
  - function is_div0(opcode_t, operand_t), returning true for DIV/MOD with operand_b==0.
- One sub-module, rr_arbiter2: inputs req[1:0] and advance; output grant[1:0]; holds rr_last internally.
- Top level: instr_reg_sched instantiates rr_arbiter2. The testbench connects it to instr_register.

## Test plan
- Reset, then requester 0 sends ADD a=5 b=3 → load_en=1 at write_pointer=0. Next cycle out_valid=1, out_word.result=8, count=1.
- Both requesters valid continuously (PASSA a=1 / PASSA a=2) → grants alternate 0,1,0,1. Entries 0..3 read back with results 1,2,1,2.
- 32 pushes with out_ready=0 → count=32 and req_ready=0. One pop → next push lands at write_pointer=0 (wrap). Reads return in push order.
- Requester 1 sends DIV a=7 b=0, then MOD a=7 b=2 → err_div0 pulses once, only MOD is stored (result 1), count=1.
- Queue holds 3 entries, assert flush while pushing → next cycle count=0 and out_valid=0. The next push goes to write_pointer=0.
- Drop reset_n mid-burst with count=10 → all outputs take their reset values asynchronously. After release, a fresh push lands at entry 0.
